qed_consistency_checker: RTL
============================

// Module: qed_consistency_checker
// PURPOSE
//  Consumer side of the SQED duplication flow. Watches the commit stream of
//  original instructions (regs r1-r15) and duplicated QED instructions
//  (regs r17-r31, rd = {1'b1, rd[3:0]}). When the original and duplicate
//  commit counts are equal and nonzero, it sweeps register pairs r[i]/r[i+16]
//  through a dedicated register-file read port and flags any mismatch.
//  Sits beside the core's register file; its outputs feed the formal property.
// PARAMETERS
//  XLEN      32   register data width
//  NHALF     16   registers per half; pairs are i / i+NHALF for i=1..NHALF-1
//  CNT_W     16   width of the original and duplicate commit counters
// PORTS
//  clk            in   1      core clock
//  rst            in   1      async reset, active-high
//  check_en       in   1      allows a sweep to start; 0 holds the block in IDLE
//  commit_valid   in   1      one instruction retires this cycle
//  commit_dup     in   1      the retiring instruction is a QED duplicate
//  rf_rd_en       out  1      read strobe for the checker read port
//  rf_raddr_a     out  5      original-register address (i)
//  rf_raddr_b     out  5      duplicate-register address (i+NHALF)
//  rf_rdata_a     in   XLEN   data for raddr_a, valid 1 cycle after rf_rd_en
//  rf_rdata_b     in   XLEN   data for raddr_b, valid 1 cycle after rf_rd_en
//  busy           out  1      sweep in progress
//  check_done     out  1      1-cycle pulse at the end of a full sweep
//  qed_consistent out  1      1-cycle pulse with check_done when all pairs match
//  qed_mismatch   out  1      sticky: some sweep found a mismatch
//  mismatch_idx   out  5      lowest mismatching i from the first failing sweep
//  order_err      out  1      sticky: dup count exceeded orig count
//  cnt_ovf        out  1      sticky: a counter saturated
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, FSM in IDLE, checked flag 0.
//  - Counters: each commit_valid cycle increments orig_cnt (commit_dup=0) or
//    dup_cnt (commit_dup=1). Counters saturate at all-ones and set cnt_ovf.
//    Any commit clears the checked flag.
//  - order_err sets in the cycle after dup_cnt > orig_cnt first becomes true.
//  - Trigger in IDLE: check_en & ~commit_valid & orig_cnt==dup_cnt &
//    orig_cnt!=0 & ~checked & ~cnt_ovf. The next state is SWEEP with idx=1.
//  - SWEEP: rf_rd_en=1, raddr_a=idx, raddr_b=idx+NHALF, idx++. After idx=NHALF-1
//    the FSM moves to DRAIN. Issue uses 15 cycles.
//  - Compare pipeline: cmp_valid/cmp_idx equal rf_rd_en/raddr_a delayed 1 cycle.
//    When cmp_valid is set, rdata_a!=rdata_b marks the sweep failed. The first
//    failing idx of the sweep is latched.
//  - DRAIN: the last compare is evaluated. Then DONE, which lasts one cycle:
//    - check_done pulses and checked is set.
//    - qed_consistent pulses if no failure.
//    - Otherwise qed_mismatch sets and mismatch_idx is loaded, only if
//      qed_mismatch was previously 0.
//    - DONE returns to IDLE.
//  - Latency: trigger cycle T gives rf_rd_en at T+1..T+15 and check_done at
//    T+17. busy is 1 from T+1 through T+17.
//  - A commit_valid during SWEEP or DRAIN aborts: the FSM returns to IDLE the
//    next cycle. No check_done, no result update, and the failure flag is
//    discarded. check_en low mid-sweep also aborts the same way.
//  - Async rst mid-sweep: immediate return to reset state; the sticky flags clear.
//  - r0/r16 are never read. The r0 mapping in the duplication logic keeps r0.
// TESTING
//  - 3 orig + 3 dup commits, regs equal, check_en=1 -> check_done and
//    qed_consistent at T+17, with raddr_a=1..15 and raddr_b=17..31 in order.
//  - r5=0x1234, r21=0x1235, counts 2/2 -> check_done=1, qed_consistent=0,
//    qed_mismatch=1, mismatch_idx=5. A second mismatch at r3 later leaves idx=5.
//  - Commit at sweep cycle 7 -> no check_done, busy drops next cycle. The sweep
//    restarts after counts re-equalise.
//  - dup commit with orig_cnt=0 -> order_err=1, no sweep ever starts.
//  - CNT_W=4, 16 orig commits -> orig_cnt=15 holds, cnt_ovf=1, no sweep triggers.
//  - rst at sweep cycle 10 -> all outputs 0 the same cycle. Equal counts
//    re-established with no new commits do not retrigger after the sweep completes.

Source files
------------

// File: rtl/qed_consistency_checker_if.sv
// Commit-stream, checker read-port and result signals of the SQED consistency checker.
// The master side is the core/register file; the slave side is the checker.
interface qed_if #(
  parameter int unsigned XLEN = 32
);
  logic            check_en;
  logic            commit_valid;
  logic            commit_dup;
  logic            rf_rd_en;
  logic [4:0]      rf_raddr_a;
  logic [4:0]      rf_raddr_b;
  logic [XLEN-1:0] rf_rdata_a;
  logic [XLEN-1:0] rf_rdata_b;
  logic            busy;
  logic            check_done;
  logic            qed_consistent;
  logic            qed_mismatch;
  logic [4:0]      mismatch_idx;
  logic            order_err;
  logic            cnt_ovf;

  modport master (
    output check_en, commit_valid, commit_dup, rf_rdata_a, rf_rdata_b,
    input  rf_rd_en, rf_raddr_a, rf_raddr_b, busy, check_done, qed_consistent,
           qed_mismatch, mismatch_idx, order_err, cnt_ovf
  );

  modport slave (
    input  check_en, commit_valid, commit_dup, rf_rdata_a, rf_rdata_b,
    output rf_rd_en, rf_raddr_a, rf_raddr_b, busy, check_done, qed_consistent,
           qed_mismatch, mismatch_idx, order_err, cnt_ovf
  );
endinterface

// File: rtl/qed_consistency_checker.sv
// SQED consumer: counts original/duplicate commits and, once they balance, sweeps
// register pairs r[i]/r[i+NHALF] through a private read port looking for divergence.
module qed_consistency_checker #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NHALF = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  qed_if.slave  chk_if
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]       LAST_IDX = 5'(NHALF - 1);
  localparam logic [4:0]       B_OFS    = 5'(NHALF);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] orig_cnt_q, orig_cnt_d;
  logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
  logic             cnt_ovf_q, cnt_ovf_d;
  logic             order_err_q;
  logic             checked_q;
  logic [4:0]       idx_q;
  logic             rd_en_q;
  logic             busy_q;
  logic             cmp_valid_q;
  logic [4:0]       cmp_idx_q;
  logic             fail_q;
  logic [4:0]       fail_idx_q;
  logic             check_done_q;
  logic             consistent_q;
  logic             mismatch_q;
  logic [4:0]       mismatch_idx_q;

  logic [XLEN-1:0]  rdata_a;
  logic [XLEN-1:0]  rdata_b;
  logic             cmp_fail;
  logic             trigger;
  logic             abort;

  assign rdata_a  = chk_if.rf_rdata_a;
  assign rdata_b  = chk_if.rf_rdata_b;
  assign cmp_fail = cmp_valid_q & (rdata_a != rdata_b);

  assign trigger = chk_if.check_en & ~chk_if.commit_valid & (orig_cnt_q == dup_cnt_q) &
                   (orig_cnt_q != '0) & ~checked_q & ~cnt_ovf_q;
  // Any retirement makes the snapshot being compared stale.
  assign abort   = chk_if.commit_valid | ~chk_if.check_en;

  always_comb begin
    orig_cnt_d = orig_cnt_q;
    dup_cnt_d  = dup_cnt_q;
    cnt_ovf_d  = cnt_ovf_q;
    if (chk_if.commit_valid) begin
      if (chk_if.commit_dup) begin
        dup_cnt_d = sat_inc(dup_cnt_q);
        if (dup_cnt_q == CNT_MAX) cnt_ovf_d = 1'b1;
      end else begin
        orig_cnt_d = sat_inc(orig_cnt_q);
        if (orig_cnt_q == CNT_MAX) cnt_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_cnt_q  <= '0;
      dup_cnt_q   <= '0;
      cnt_ovf_q   <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      orig_cnt_q  <= orig_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
      cnt_ovf_q   <= cnt_ovf_d;
      order_err_q <= order_err_q | (dup_cnt_q > orig_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      checked_q      <= 1'b0;
      idx_q          <= '0;
      rd_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      cmp_valid_q    <= 1'b0;
      cmp_idx_q      <= '0;
      fail_q         <= 1'b0;
      fail_idx_q     <= '0;
      check_done_q   <= 1'b0;
      consistent_q   <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_idx_q <= '0;
    end else begin
      // p1: compare stage sees the read issued one cycle earlier
      cmp_valid_q  <= rd_en_q;
      cmp_idx_q    <= idx_q;
      check_done_q <= 1'b0;
      consistent_q <= 1'b0;
      if (chk_if.commit_valid) checked_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q    <= SWEEP;
            idx_q      <= 5'd1;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
          end else begin
            if (cmp_fail && !fail_q) begin
              fail_q     <= 1'b1;
              fail_idx_q <= cmp_idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
              rd_en_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
          end else begin
            state_q      <= DONE;
            check_done_q <= 1'b1;
            checked_q    <= 1'b1;
            if (!(fail_q || cmp_fail)) begin
              consistent_q <= 1'b1;
            end else if (!mismatch_q) begin
              mismatch_q     <= 1'b1;
              mismatch_idx_q <= fail_q ? fail_idx_q : cmp_idx_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_if.rf_rd_en       = rd_en_q;
  assign chk_if.rf_raddr_a     = rd_en_q ? idx_q : 5'd0;
  assign chk_if.rf_raddr_b     = rd_en_q ? idx_q + B_OFS : 5'd0;
  assign chk_if.busy           = busy_q;
  assign chk_if.check_done     = check_done_q;
  assign chk_if.qed_consistent = consistent_q;
  assign chk_if.qed_mismatch   = mismatch_q;
  assign chk_if.mismatch_idx   = mismatch_idx_q;
  assign chk_if.order_err      = order_err_q;
  assign chk_if.cnt_ovf        = cnt_ovf_q;

endmodule
